// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with row sync, ghost rejection and debounce
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in,
    output logic [3:0] out,
    output logic [4:0] y,
    output logic       key_valid,
    output logic       key_held
);

    localparam int              DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0]      DB_TARGET  = 4'(DEBOUNCE_SCANS);
    localparam logic [4:0]      NO_KEY     = 5'd16;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESSED = 1'b1
    } state_t;

    // Synchroniser and column drive
    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [DW-1:0] r_dwell;
    logic [1:0]    r_col;
    logic [3:0]    r_out;

    // Scan accumulator: hit count saturates at 2 (meaning "more than one")
    logic [1:0]    r_acc_hits;
    logic [3:0]    r_acc_code;
    logic          r_acc_multi;

    // Debounce
    logic [4:0]    r_cand;
    logic [3:0]    r_cnt;
    logic [4:0]    r_y;
    logic          r_key_valid;
    state_t        r_state;

    logic          w_sample;
    logic          w_scan_done;
    logic          w_row_single;
    logic          w_row_multi;
    logic [1:0]    w_row_idx;
    logic [1:0]    w_new_hits;
    logic [3:0]    w_new_code;
    logic          w_new_multi;
    logic [4:0]    w_scan_result;
    logic [4:0]    w_cand_nxt;
    logic [3:0]    w_cnt_nxt;
    logic          w_commit;
    state_t        w_state_nxt;
    logic [4:0]    w_y_nxt;
    logic          w_valid_nxt;

    assign w_sample    = (r_dwell == DWELL_LAST);
    assign w_scan_done = w_sample && (r_col == 2'd3);

    // Two-flop synchroniser on the asynchronous row lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
        end else begin
            r_sync1 <= in;
            r_sync2 <= r_sync1;
        end
    end

    // Dwell counter and one-hot column rotation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell <= '0;
            r_col   <= 2'd0;
            r_out   <= 4'b0001;
        end else if (w_sample) begin
            r_dwell <= '0;
            r_col   <= r_col + 2'd1;
            r_out   <= {r_out[2:0], r_out[3]};
        end else begin
            r_dwell <= r_dwell + DW'(1);
        end
    end

    // Classify the synchronised rows for the current column
    always_comb begin
        w_row_single = 1'b0;
        w_row_multi  = 1'b0;
        w_row_idx    = 2'd0;
        case (r_sync2)
            4'b0000: ;
            4'b0001: begin w_row_single = 1'b1; w_row_idx = 2'd0; end
            4'b0010: begin w_row_single = 1'b1; w_row_idx = 2'd1; end
            4'b0100: begin w_row_single = 1'b1; w_row_idx = 2'd2; end
            4'b1000: begin w_row_single = 1'b1; w_row_idx = 2'd3; end
            default: w_row_multi = 1'b1;
        endcase
    end

    // Fold this column's contribution into the scan so far and form the scan result
    always_comb begin
        w_new_hits  = r_acc_hits;
        w_new_code  = r_acc_code;
        w_new_multi = r_acc_multi | w_row_multi;
        if (w_row_single) begin
            w_new_code = {r_col, w_row_idx};
            if (r_acc_hits != 2'd2) begin
                w_new_hits = r_acc_hits + 2'd1;
            end
        end
        if ((w_new_hits == 2'd1) && !w_new_multi) begin
            w_scan_result = {1'b0, w_new_code};
        end else begin
            w_scan_result = NO_KEY;
        end
    end

    // Accumulator update at each sample; emptied after column 3 so each scan starts clean
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_hits  <= 2'd0;
            r_acc_code  <= 4'd0;
            r_acc_multi <= 1'b0;
        end else if (w_scan_done) begin
            r_acc_hits  <= 2'd0;
            r_acc_code  <= 4'd0;
            r_acc_multi <= 1'b0;
        end else if (w_sample) begin
            r_acc_hits  <= w_new_hits;
            r_acc_code  <= w_new_code;
            r_acc_multi <= w_new_multi;
        end
    end

    // Candidate tracking: a differing scan restarts the stable count at 1
    always_comb begin
        w_cand_nxt = r_cand;
        w_cnt_nxt  = r_cnt;
        if (w_scan_result == r_cand) begin
            if (r_cnt != DB_TARGET) begin
                w_cnt_nxt = r_cnt + 4'd1;
            end
        end else begin
            w_cand_nxt = w_scan_result;
            w_cnt_nxt  = 4'd1;
        end
        w_commit = w_scan_done && (w_cnt_nxt == DB_TARGET) && (w_cand_nxt != r_y);
    end

    // Candidate and stable count registers, advanced once per scan
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand <= NO_KEY;
            r_cnt  <= 4'd0;
        end else if (w_scan_done) begin
            r_cand <= w_cand_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    // Debounce FSM next state, committed code and press pulse
    always_comb begin
        w_state_nxt = r_state;
        w_y_nxt     = r_y;
        w_valid_nxt = 1'b0;
        if (w_commit) begin
            w_y_nxt = w_cand_nxt;
            case (r_state)
                IDLE: begin
                    if (w_cand_nxt != NO_KEY) begin
                        w_state_nxt = PRESSED;
                        w_valid_nxt = 1'b1;
                    end
                end
                PRESSED: begin
                    if (w_cand_nxt == NO_KEY) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = PRESSED;
                        w_valid_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Debounce FSM state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_y         <= NO_KEY;
            r_key_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_y         <= w_y_nxt;
            r_key_valid <= w_valid_nxt;
        end
    end

    assign out       = r_out;
    assign y         = r_y;
    assign key_valid = r_key_valid;
    assign key_held  = (r_state == PRESSED);

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Drives the column lines of the 4x4 matrix keypad and samples its row lines. Synchronises and debounces the rows, then reports one debounced key code per press. This is the driving end of the keypad interface: it generates the one-hot column strobe that the key-decode logic consumes. Its key numbering (code = 4·column_index + row_index, 16 = no key) matches that decode exactly, so downstream guess logic sees identical codes from either path.

## Interface
- SCAN_DIV, 1000: clock cycles each column is driven (dwell); minimum 4.
- DEBOUNCE_SCANS, 4: consecutive identical full-scan results needed to commit a change; minimum 1, maximum 15.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  4  raw row sense lines from the keypad, one-hot when a key is pressed; asynchronous to clk.
- out  output  4  one-hot column drive, registered.
- y  output  5  committed key code 0–15; 16 = no key.
- key_valid  output  1  one-cycle pulse when a new key (0–15) is committed.
- key_held  output  1  high while the committed code is not 16.

## Operation
- Reset values: out=4'b0001, y=16, key_valid=0, key_held=0. Column index 0, dwell counter 0, candidate=16, stable count 0, synchroniser flops 0.
- in passes through a 2-flop synchroniser before use.
- Column drive:
  - Dwell counter runs 0..SCAN_DIV-1.
  - On wrap, out rotates 0001→0010→0100→1000→0001 and the column index increments mod 4.
- Sampling:
  - On the cycle the dwell counter equals SCAN_DIV-1, the synchronised rows are evaluated for the current column.
  - Exactly one row bit set at index r: the column hit is 4·c + r.
  - Zero bits set: no hit.
  - More than one bit set: flagged as multi-press.
- Scan accumulator covers columns 0..3 of one scan:
  - Scan result = the single hit code if exactly one hit occurred across all 4 columns and no multi-press flag.
  - Otherwise (no hits, several hits, or multi-press) the result is 16. Ghost and chord rejection is required.
- Debounce FSM (states IDLE, PRESSED), evaluated once per scan at the column-3 sample:
  - If scan result == candidate: stable count increments, saturating at DEBOUNCE_SCANS.
  - Otherwise: candidate := scan result and stable count := 1.
  - Commit when stable count reaches DEBOUNCE_SCANS (same cycle it is reached) and candidate != y: y := candidate.
  - IDLE→PRESSED on commit of a code 0–15; key_valid pulses 1 cycle.
  - PRESSED→IDLE on commit of 16; no pulse.
  - PRESSED→PRESSED on commit of a different code 0–15 (direct change without an observed release); key_valid pulses.
  - No re-pulse while the same key stays held.
- key_held = (state == PRESSED); it is registered and updates in the same cycle as y.
- The accumulator clears at the start of every scan (column 0 dwell start).

## Timing
- Scan period: 4·SCAN_DIV cycles.
- Row sampling uses data driven ≥ SCAN_DIV-3 cycles after the column change, which allows 2 synchroniser cycles plus settling.
- y, key_held and key_valid change in the cycle after the column-3 sample edge. key_valid is high for exactly that one cycle.
- Press latency (key stable from before the scan start): DEBOUNCE_SCANS scans plus 1 cycle, counted from the start of the first full scan in which the key is seen.
- Release latency: the same.
- Reset assertion mid-scan forces all reset values immediately (asynchronously). Scanning restarts on column 0 with a full dwell after deassertion.
- A glitch shorter than one scan resets the stable count. y is unchanged unless DEBOUNCE_SCANS == 1.

## Test plan
- Reset check (SCAN_DIV=4, DEBOUNCE_SCANS=3): hold rst_n low, then release → out=0001, y=16, key_valid=0. out rotates every 4 cycles with a 16-cycle period.
- Single press: in=0100 whenever out=0010 (key 6) for 5 scans → y=6 and key_held=1 after the 3rd qualifying scan. Exactly one key_valid pulse; no further pulses.
- Release: then in=0000 → y=16 and key_held=0 after 3 scans, with no key_valid pulse.
- Bounce: key 13 present for 2 scans, absent 1 scan, then present for 3 scans → exactly one commit (y=13), occurring at the end of the 6th scan.
- Chord and ghost rejection:
  - Keys 0 and 15 pressed together (in=0001 on column 0, in=1000 on column 3) → y stays 16 and no pulse.
  - in=0011 on column 1 → y stays 16 and no pulse.
- Key change and reset: key 2 committed, then key 9 held → y goes 2→9 with one key_valid pulse. Asserting rst_n low mid-dwell → out=0001 and y=16 immediately.
